// File: rtl/alu_bcond_unit.sv
// alu_bcond_unit: registered RV32I execute slice (adder, shifter, comparator, branch condition).
// Optional macro ALU_BR_TAKEN_EN adds the registered br_taken flag output.
module alu_bcond_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic [XLEN-1:0] imm,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3_adder,
    input  logic [2:0]      funct3_shift,
    input  logic [2:0]      funct3_comp,
    input  logic [2:0]      funct3,
`ifdef ALU_BR_TAKEN_EN
    output logic            br_taken,
`endif
    output logic [XLEN-1:0] adder_rsv,
    output logic [XLEN-1:0] shifter_rsv,
    output logic [XLEN-1:0] comparator_rsv,
    output logic [XLEN-1:0] branc_add
);

    logic [XLEN-1:0] a_next;
    logic [XLEN-1:0] s_next;
    logic [XLEN-1:0] c_next;
    logic [XLEN-1:0] b_next;
    logic [4:0]      shamt;
    logic            taken;

    assign shamt = op2[4:0];

    // Adder and bitwise logic; SUB needs the exact 0100000 funct7 pattern.
    always_comb begin
        a_next = '0;
        case (funct3_adder)
            3'b000: a_next = (funct7 == 7'b0100000) ? op1 - op2 : op1 + op2;
            3'b100: a_next = op1 ^ op2;
            3'b110: a_next = op1 | op2;
            3'b111: a_next = op1 & op2;
            default: a_next = '0;
        endcase
    end

    // Barrel shifter; only the low five bits of op2 form the shift amount.
    always_comb begin
        s_next = '0;
        case (funct3_shift)
            3'b001: s_next = op1 << shamt;
            3'b101: begin
                if (funct7[5])
                    s_next = XLEN'($signed(op1) >>> shamt);
                else
                    s_next = op1 >> shamt;
            end
            default: s_next = '0;
        endcase
    end

    // Set-less-than comparator, signed or unsigned.
    always_comb begin
        c_next = '0;
        case (funct3_comp)
            3'b010: c_next = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
            3'b011: c_next = {{(XLEN-1){1'b0}}, op1 < op2};
            default: c_next = '0;
        endcase
    end

    // Branch decision from this cycle's adder and comparator results.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:         taken = (a_next == '0);
            3'b001:         taken = (a_next != '0);
            3'b100, 3'b110: taken = c_next[0];
            3'b101, 3'b111: taken = ~c_next[0];
            default:        taken = 1'b0;
        endcase
        b_next = taken ? imm : '0;
    end

    // Result registers: cleared by reset, captured only when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_rsv      <= '0;
            shifter_rsv    <= '0;
            comparator_rsv <= '0;
            branc_add      <= '0;
        end else if (en) begin
            adder_rsv      <= a_next;
            shifter_rsv    <= s_next;
            comparator_rsv <= c_next;
            branc_add      <= b_next;
        end
    end

`ifdef ALU_BR_TAKEN_EN
    // Taken flag register, timed exactly like branc_add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            br_taken <= 1'b0;
        else if (en)
            br_taken <= taken;
    end
`endif

endmodule

// File: tb/tb_alu_bcond_unit.sv
// tb_alu_bcond_unit: self-checking bench for alu_bcond_unit.
// Directed cases, randomized checks against an arithmetic model, en-hold and reset.
module tb_alu_bcond_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] op1 = '0, op2 = '0, imm = '0;
    logic [6:0]  funct7 = '0;
    logic [2:0]  funct3_adder = '0, funct3_shift = '0;
    logic [2:0]  funct3_comp = '0, funct3 = '0;
    logic [31:0] adder_rsv, shifter_rsv, comparator_rsv, branc_add;
`ifdef ALU_BR_TAKEN_EN
    logic        br_taken;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] e_a, e_s, e_c, e_b;
    logic        e_t;

    always #5 clk = ~clk;

    alu_bcond_unit #(.XLEN(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .op1(op1),
        .op2(op2),
        .imm(imm),
        .funct7(funct7),
        .funct3_adder(funct3_adder),
        .funct3_shift(funct3_shift),
        .funct3_comp(funct3_comp),
        .funct3(funct3),
`ifdef ALU_BR_TAKEN_EN
        .br_taken(br_taken),
`endif
        .adder_rsv(adder_rsv),
        .shifter_rsv(shifter_rsv),
        .comparator_rsv(comparator_rsv),
        .branc_add(branc_add)
    );

    typedef struct {
        logic [31:0] a, b, im;
        logic [6:0]  f7;
        logic [2:0]  fa, fs, fc, fb;
        logic [31:0] xa, xs, xc, xb;
        logic        xt;
    } dir_t;

    // Behavioural reference built from plain 64-bit arithmetic.
    function automatic void model(
        input  logic [31:0] a, b, im,
        input  logic [6:0]  f7,
        input  logic [2:0]  fa, fs, fc, fb,
        output logic [31:0] ra, rs, rc, rb,
        output logic        rt);
        longint ua, ub, sa, sb, pw, q;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pw = longint'(1) << b[4:0];
        ra = 32'd0;
        rs = 32'd0;
        rc = 32'd0;
        rt = 1'b0;
        case (fa)
            3'd0: ra = (f7 == 7'h20) ? 32'(ua - ub) : 32'(ua + ub);
            3'd4: ra = a ^ b;
            3'd6: ra = a | b;
            3'd7: ra = a & b;
            default: ra = 32'd0;
        endcase
        if (fs == 3'd1)
            rs = 32'(ua * pw);
        else if (fs == 3'd5) begin
            if (f7[5]) begin
                q = sa / pw;
                if (sa < 0 && (sa % pw) != 0) q = q - 1;
                rs = 32'(q);
            end else
                rs = 32'(ua / pw);
        end
        if (fc == 3'd2) rc = (sa < sb) ? 32'd1 : 32'd0;
        if (fc == 3'd3) rc = (ua < ub) ? 32'd1 : 32'd0;
        case (fb)
            3'd0: rt = (ra == 32'd0);
            3'd1: rt = (ra != 32'd0);
            3'd4, 3'd6: rt = (rc == 32'd1);
            3'd5, 3'd7: rt = (rc == 32'd0);
            default: rt = 1'b0;
        endcase
        rb = rt ? im : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, b, im, input logic [6:0] f7,
                         input logic [2:0] fa, fs, fc, fb);
        op1 = a; op2 = b; imm = im; funct7 = f7;
        funct3_adder = fa; funct3_shift = fs;
        funct3_comp = fc; funct3 = fb;
    endtask

    task automatic test_reset();
        en = 1'b1;
        drive(32'd7, 32'd7, 32'd99, 7'h20, 3'd0, 3'd1, 3'd2, 3'd0);
        step();
        step();
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_hold: got %h %h %h %h want all 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
        rst_n = 1'b1;
        en = 1'b0;
        step();
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_release_noen: got %h %h %h %h want all 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
`ifdef ALU_BR_TAKEN_EN
        n_cmp++;
        if (br_taken !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_br_taken: got %b want 0", br_taken);
        end
`endif
    endtask

    task automatic test_directed();
        dir_t t[$];
        t.push_back('{32'd10, 32'd12, 32'd30, 7'h20, 3'd0, 3'd0, 3'd0, 3'd0,
                      32'hFFFFFFFE, 32'd0, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'd10, 32'd10, 32'd30, 7'h20, 3'd0, 3'd0, 3'd0, 3'd1,
                      32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'd10, 32'd11, 32'd30, 7'h20, 3'd0, 3'd0, 3'd0, 3'd1,
                      32'hFFFFFFFF, 32'd0, 32'd0, 32'd30, 1'b1});
        t.push_back('{32'd20, 32'hFFFFFFF6, 32'd30, 7'h20, 3'd0, 3'd0, 3'd2, 3'd4,
                      32'd30, 32'd0, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'd20, 32'd30, 32'd30, 7'h20, 3'd0, 3'd0, 3'd3, 3'd6,
                      32'hFFFFFFF6, 32'd0, 32'd1, 32'd30, 1'b1});
        t.push_back('{32'd20, 32'd30, 32'd30, 7'h20, 3'd0, 3'd0, 3'd2, 3'd5,
                      32'hFFFFFFF6, 32'd0, 32'd1, 32'd0, 1'b0});
        t.push_back('{32'd20, 32'd30, 32'd30, 7'h20, 3'd0, 3'd0, 3'd3, 3'd7,
                      32'hFFFFFFF6, 32'd0, 32'd1, 32'd0, 1'b0});
        t.push_back('{32'd30, 32'd30, 32'd30, 7'h20, 3'd0, 3'd0, 3'd2, 3'd5,
                      32'd0, 32'd0, 32'd0, 32'd30, 1'b1});
        t.push_back('{32'h80000000, 32'd4, 32'd0, 7'h20, 3'd0, 3'd5, 3'd0, 3'd2,
                      32'h7FFFFFFC, 32'hF8000000, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'h80000000, 32'd4, 32'd0, 7'h00, 3'd0, 3'd5, 3'd0, 3'd2,
                      32'h80000004, 32'h08000000, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'h80000000, 32'h7FFFFFFF, 32'd55, 7'h00, 3'd4, 3'd1, 3'd2, 3'd4,
                      32'hFFFFFFFF, 32'd0, 32'd1, 32'd55, 1'b1});
        t.push_back('{32'h80000000, 32'h7FFFFFFF, 32'd55, 7'h00, 3'd7, 3'd1, 3'd3, 3'd4,
                      32'd0, 32'd0, 32'd0, 32'd0, 1'b0});
        t.push_back('{32'd5, 32'd5, 32'd0, 7'h20, 3'd0, 3'd0, 3'd0, 3'd0,
                      32'd0, 32'd0, 32'd0, 32'd0, 1'b1});
        en = 1'b1;
        foreach (t[i]) begin
            drive(t[i].a, t[i].b, t[i].im, t[i].f7,
                  t[i].fa, t[i].fs, t[i].fc, t[i].fb);
            step();
            n_cmp++;
            if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !==
                {t[i].xa, t[i].xs, t[i].xc, t[i].xb}) begin
                n_bad++;
                $display("FAIL directed_%0d: got %h %h %h %h want %h %h %h %h", i,
                         adder_rsv, shifter_rsv, comparator_rsv, branc_add,
                         t[i].xa, t[i].xs, t[i].xc, t[i].xb);
            end
`ifdef ALU_BR_TAKEN_EN
            n_cmp++;
            if (br_taken !== t[i].xt) begin
                n_bad++;
                $display("FAIL directed_taken_%0d: got %b want %b", i, br_taken, t[i].xt);
            end
`endif
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] c [6];
        c[0] = 32'h0; c[1] = 32'h80000000; c[2] = 32'h7FFFFFFF;
        c[3] = 32'hFFFFFFFF; c[4] = 32'h1; c[5] = 32'($urandom_range(0, 40));
        if ($urandom_range(0, 2) == 0)
            return c[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_random();
        logic [31:0] a, b, im, ra, rs, rc, rb;
        logic [6:0]  f7;
        logic        rt;
        for (int i = 0; i < 300; i++) begin
            a = pick();
            b = ($urandom_range(0, 4) == 0) ? a : pick();
            im = $urandom;
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            drive(a, b, im, f7, 3'($urandom), 3'($urandom),
                  3'($urandom), 3'($urandom));
            en = ($urandom_range(0, 7) != 0);
            model(a, b, im, f7, funct3_adder, funct3_shift,
                  funct3_comp, funct3, ra, rs, rc, rb, rt);
            if (en) begin
                e_a = ra; e_s = rs; e_c = rc; e_b = rb; e_t = rt;
            end
            step();
            n_cmp++;
            if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !==
                {e_a, e_s, e_c, e_b}) begin
                n_bad++;
                $display("FAIL random_%0d: got %h %h %h %h want %h %h %h %h", i,
                         adder_rsv, shifter_rsv, comparator_rsv, branc_add,
                         e_a, e_s, e_c, e_b);
            end
`ifdef ALU_BR_TAKEN_EN
            n_cmp++;
            if (br_taken !== e_t) begin
                n_bad++;
                $display("FAIL random_taken_%0d: got %b want %b", i, br_taken, e_t);
            end
`endif
        end
    endtask

    task automatic test_en_hold();
        en = 1'b1;
        drive(32'd10, 32'd11, 32'd30, 7'h20, 3'd0, 3'd5, 3'd3, 3'd1);
        step();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, $urandom, 7'h20, 3'd4, 3'd1, 3'd2, 3'd0);
            step();
            n_cmp++;
            if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !==
                {32'hFFFFFFFF, 32'd0, 32'd1, 32'd30}) begin
                n_bad++;
                $display("FAIL en_hold_%0d: got %h %h %h %h want ffffffff 0 1 1e", i,
                         adder_rsv, shifter_rsv, comparator_rsv, branc_add);
            end
        end
    endtask

    task automatic test_reset_mid();
        en = 1'b1;
        drive(32'h80000000, 32'd4, 32'd77, 7'h20, 3'd6, 3'd5, 3'd2, 3'd4);
        step();
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !==
            {32'h80000004, 32'hF8000000, 32'd1, 32'd77}) begin
            n_bad++;
            $display("FAIL pre_reset: got %h %h %h %h want 80000004 f8000000 1 4d",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
        drive(32'd3, 32'd3, 32'd9, 7'h20, 3'd6, 3'd1, 3'd3, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !== 128'd0) begin
            n_bad++;
            $display("FAIL async_clear: got %h %h %h %h want all 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
        step();
        rst_n = 1'b1;
        en = 1'b0;
        step();
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !== 128'd0) begin
            n_bad++;
            $display("FAIL inflight_discard: got %h %h %h %h want all 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
        en = 1'b1;
        step();
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !==
            {32'd3, 32'd24, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL post_reset: got %h %h %h %h want 3 18 0 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
    endtask

    initial begin
        e_a = '0; e_s = '0; e_c = '0; e_b = '0; e_t = 1'b0;
        #1;
        n_cmp++;
        if ({adder_rsv, shifter_rsv, comparator_rsv, branc_add} !== 128'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h %h %h %h want all 0",
                     adder_rsv, shifter_rsv, comparator_rsv, branc_add);
        end
        test_reset();
        test_directed();
        test_en_hold();
        en = 1'b1;
        drive(32'd0, 32'd0, 32'd0, 7'h00, 3'd1, 3'd0, 3'd0, 3'd2);
        step();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
